// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle core: word width, fetch FSM
// encodings and default reset/exception vectors.
package mips_pkg;

  localparam int unsigned WordWidth = 32;

  typedef logic [WordWidth-1:0] word_t;
  typedef logic [1:0]           fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StReq   = 2'd1;
  localparam fetch_state_t StValid = 2'd2;

  localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEFAULT   = 32'h0000_0080;

  function automatic logic is_word_aligned(input word_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jump > branch > sequential) with alignment handling.
// PC_ALIGN_TRAP_EN selects trapping to EXC_VECTOR instead of silently forcing alignment.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic  [WordWidth-1:0] pc_plus4,
  input  logic                  branch_taken,
  input  logic  [WordWidth-1:0] branch_target,
  input  logic                  jump,
  input  logic  [WordWidth-1:0] jump_target,
  output logic  [WordWidth-1:0] next_pc,
  output logic                  misaligned
);

  word_t selected;

  always_comb begin
    selected = pc_plus4;
    if (jump) begin
      selected = jump_target;
    end else if (branch_taken) begin
      selected = branch_target;
    end
  end

`ifdef PC_ALIGN_TRAP_EN
  always_comb begin
    misaligned = !is_word_aligned(selected);
    next_pc    = misaligned ? EXC_VECTOR : selected;
  end
`else
  // Low bits are discarded, so a misaligned target lands on its enclosing word.
  logic unused_bits;
  assign unused_bits = ^{EXC_VECTOR, selected[1:0]};
  assign next_pc     = {selected[WordWidth-1:2], 2'b00};
  assign misaligned  = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: IDLE -> REQ -> VALID handshake with
// instruction memory. Optional misalignment trap via the PC_ALIGN_TRAP_EN macro.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter word_t EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WordWidth-1:0] pc,
  input  logic [WordWidth-1:0] pc_plus4,
  input  logic                 branch_taken,
  input  logic [WordWidth-1:0] branch_target,
  input  logic                 jump,
  input  logic [WordWidth-1:0] jump_target,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [WordWidth-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic [WordWidth-1:0] imem_rdata,
  output logic [WordWidth-1:0] instr,
  output logic                 instr_valid,
  output logic [WordWidth-1:0] retire_count,
  output logic                 misalign
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        retire_q, retire_d;
  logic         misalign_q, misalign_d;

  word_t        next_pc;
  logic         next_misaligned;

  next_pc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .misaligned    (next_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retire_d   = retire_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        // Decode control inputs only matter on the retiring edge.
        if (!stall) begin
          pc_d       = next_pc;
          retire_d   = retire_q + 32'd1;
          misalign_d = next_misaligned;
          state_d    = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      retire_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign imem_req     = (state_q == StReq);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = (state_q == StValid);
  assign retire_count = retire_q;
  assign misalign     = misalign_q;

endmodule
